// File: rtl/row_sync_pkg.sv
// row_sync_pkg: FSM state encoding and row-geometry helper shared by the row sync engine files.
// Feature macro used by the engine: ROW_SYNC_TIMEOUT_EN (adds the backing-progress watchdog).
package row_sync_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_RD   = 3'd1,
    WB_WR   = 3'd2,
    FL_ISS  = 3'd3,
    FL_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic int words_per_row(input int colw);
    return 1 << colw;
  endfunction

endpackage

// File: rtl/row_sync_wdog.sv
// row_sync_wdog: counts active cycles without backing progress; expires at TIMEOUT and latches a sticky error.
// Only instantiated when ROW_SYNC_TIMEOUT_EN is defined.
module row_sync_wdog
  import row_sync_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_progress,
  output logic o_expire,
  output logic o_err
);

  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] r_cnt;
  logic            r_err;

  // Expire on the stalled cycle that would bring the count to TIMEOUT, so the
  // engine reaches DONE on the following cycle.
  assign o_expire = i_active && !i_progress && (r_cnt == CNTW'(TIMEOUT - 1));
  assign o_err    = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!i_active || i_progress || o_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (o_expire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_sync_engine.sv
// row_sync_engine: moves one full row between the cache row buffer and backing store, then pulses sync.
// Optional watchdog via ROW_SYNC_TIMEOUT_EN; when undefined err is tied low and no watchdog exists.
module row_sync_engine
  import row_sync_pkg::*;
#(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 5,
  parameter int DWIDTH    = 64
`ifdef ROW_SYNC_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 255
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wb,
  input  logic [CHWIDTH-1:0]            req_crow,
  input  logic [ADDRWIDTH-1:0]          req_row,
  output logic [CHWIDTH+COLWIDTH-1:0]   c_addr,
  output logic                          c_re,
  output logic                          c_we,
  output logic [DWIDTH-1:0]             c_wdata,
  input  logic [DWIDTH-1:0]             c_rdata,
  output logic                          b_valid,
  input  logic                          b_ready,
  output logic                          b_we,
  output logic [ADDRWIDTH+COLWIDTH-1:0] b_addr,
  output logic [DWIDTH-1:0]             b_wdata,
  input  logic                          b_rvalid,
  input  logic [DWIDTH-1:0]             b_rdata,
  output logic                          sync,
  output logic                          busy,
  output logic                          err,
  output logic [2:0]                    o_dbg_state
);

  localparam logic [COLWIDTH:0] LAST_COL = (COLWIDTH + 1)'(words_per_row(COLWIDTH) - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [CHWIDTH-1:0]     r_crow;
  logic [ADDRWIDTH-1:0]   r_row;
  logic [COLWIDTH:0]      r_col;    // writeback column / fill issue column
  logic [COLWIDTH:0]      r_rcol;   // fill response column
  logic                   r_first;  // first WB_WR cycle: c_rdata is live this cycle
  logic [DWIDTH-1:0]      r_wdata;
  logic                   w_fill_rx;
  logic                   w_issue;
  logic                   w_expire;

  // Handshakes: a request moves on the edge where req_valid && req_ready; a backing
  // command moves on the edge where b_valid && b_ready, and b_valid/b_addr/b_wdata
  // stay stable until then. b_rvalid carries no backpressure.
  assign req_ready   = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;
  assign w_issue     = ((r_state == WB_WR) || (r_state == FL_ISS)) && b_ready;
  assign w_fill_rx   = ((r_state == FL_ISS) || (r_state == FL_WAIT)) && b_rvalid && !r_rcol[COLWIDTH];

`ifdef ROW_SYNC_TIMEOUT_EN
  logic w_active;
  logic w_progress;

  assign w_active   = (r_state != IDLE) && (r_state != DONE);
  assign w_progress = w_issue || b_rvalid;

  row_sync_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_progress(w_progress),
    .o_expire  (w_expire),
    .o_err     (err)
  );
`else
  assign w_expire = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_crow  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_rcol  <= '0;
      r_first <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_first <= (r_state == WB_RD);
      if (r_first) begin
        r_wdata <= c_rdata;
      end
      if ((r_state == IDLE) && req_valid) begin
        r_crow <= req_crow;
        r_row  <= req_row;
        r_col  <= '0;
        r_rcol <= '0;
      end
      if (w_issue) begin
        r_col <= r_col + 1'b1;
      end
      if (w_fill_rx) begin
        r_rcol <= r_rcol + 1'b1;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    c_re    = 1'b0;
    c_we    = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    b_valid = 1'b0;
    b_we    = 1'b0;
    b_addr  = '0;
    b_wdata = '0;
    sync    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next = req_wb ? WB_RD : FL_ISS;
        end
      end
      WB_RD: begin
        c_re   = 1'b1;
        c_addr = {r_crow, r_col[COLWIDTH-1:0]};
        w_next = WB_WR;
      end
      WB_WR: begin
        b_valid = 1'b1;
        b_we    = 1'b1;
        b_addr  = {r_row, r_col[COLWIDTH-1:0]};
        b_wdata = r_first ? c_rdata : r_wdata;
        if (b_ready) begin
          w_next = (r_col == LAST_COL) ? DONE : WB_RD;
        end
      end
      FL_ISS: begin
        b_valid = 1'b1;
        b_addr  = {r_row, r_col[COLWIDTH-1:0]};
        if (b_ready && (r_col == LAST_COL)) begin
          w_next = FL_WAIT;
        end
      end
      FL_WAIT: begin
        if (r_rcol[COLWIDTH] || (b_rvalid && (r_rcol == LAST_COL))) begin
          w_next = DONE;
        end
      end
      DONE: begin
        sync   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Fill responses land in the cache in arrival order, during issue or wait.
    if (w_fill_rx) begin
      c_we    = 1'b1;
      c_addr  = {r_crow, r_rcol[COLWIDTH-1:0]};
      c_wdata = b_rdata;
    end
    if (w_expire) begin
      w_next = DONE;
    end
  end

endmodule
